fifo_rd_packer: RTL and testbench

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

---
 rtl/fifo_pkg.sv | 17 +
 rtl/out_reg_slice.sv | 36 +++
 rtl/fifo_rd_packer.sv | 151 +++++++++++++++
 tb/tb_fifo_rd_packer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for FIFO-side helpers: packer FSM encoding and lane-count sizing.
package fifo_pkg;

    // Packer states: FILL collects lanes, DRAIN absorbs the last in-flight read,
    // HOLD waits for the output register to accept the assembled word.
    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } pack_state_e;

    // Width needed to count lanes from 0 up to and including ratio.
    function automatic int cnt_width(input int ratio);
        return $clog2(ratio + 1);
    endfunction

endpackage

// File: rtl/out_reg_slice.sv
// Valid/ready holding register: loads when empty or when the held word is being
// accepted, otherwise keeps valid and payload stable.
module out_reg_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    assign s_ready = !valid_q || m_ready;
    assign m_valid = valid_q;
    assign m_data  = data_q;

    // Load a new word when there is room; drop valid once the held word is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (s_ready) begin
            valid_q <= s_valid;
            if (s_valid) begin
                data_q <= s_data;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Reads narrow words from a sync FIFO (one-cycle read latency) and packs them into
// wide words with per-lane keep flags; partial words leave on flush or idle timeout.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_RATIO = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             fifo_rd_rdy,
    output logic                             fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]            fifo_data,
    input  logic                             flush,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
    output logic [PACK_RATIO-1:0]            m_keep
);

    localparam int CW = cnt_width(PACK_RATIO);
    localparam int IW = $clog2(TIMEOUT);
    localparam int OW = DATA_WIDTH * PACK_RATIO;

    pack_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          pending_q;

    logic          capture;
    logic          full_now;
    logic          timeout;
    logic          close_req;
    logic          rd_en;
    logic          xfer_valid;
    logic          xfer_ready;
    logic          xfer;
    logic [OW-1:0] acc_flat;
    logic [PACK_RATIO-1:0] keep_vec;

    // A read issued last cycle delivers its data now.
    assign capture   = pending_q && (state_q != HOLD);
    assign full_now  = capture && (cnt_q == CW'(PACK_RATIO - 1));
    assign timeout   = (idle_q == IW'(TIMEOUT - 1));
    assign close_req = flush || timeout;
    assign xfer      = xfer_valid && xfer_ready;

    // Never strobe the FIFO while reset is asserted.
    assign fifo_rd_en = rd_en && !reset;

    // Next state, lane count and read issue.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_en      = 1'b0;
        xfer_valid = 1'b0;
        if (capture) begin
            cnt_d = cnt_q + CW'(1);
        end
        case (state_q)
            FILL: begin
                if (full_now) begin
                    state_d = HOLD;
                end else if (close_req && pending_q) begin
                    state_d = DRAIN;
                end else if (close_req && (cnt_q != '0)) begin
                    state_d = HOLD;
                end else if (fifo_rd_rdy &&
                             (int'(cnt_q) + int'(pending_q) + 1 <= PACK_RATIO)) begin
                    // Reads are only issued while every in-flight word has a free lane.
                    rd_en = 1'b1;
                end
            end
            DRAIN: begin
                state_d = HOLD;
            end
            HOLD: begin
                xfer_valid = 1'b1;
                if (xfer_ready) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Idle counter: restarts on each capture, on transfer and while empty.
    always_comb begin
        idle_d = idle_q;
        if (capture || xfer || (cnt_q == '0)) begin
            idle_d = '0;
        end else if (state_q == FILL) begin
            idle_d = idle_q + IW'(1);
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            idle_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idle_q    <= idle_d;
            pending_q <= fifo_rd_en;
        end
    end

    // One register per lane; lane 0 sits in the least significant bits.
    for (genvar gi = 0; gi < PACK_RATIO; gi++) begin : g_lane
        logic [DATA_WIDTH-1:0] lane_q;

        // Capture into this lane when it is next in line; clear after hand-off.
        always_ff @(posedge clk) begin
            if (reset || xfer) begin
                lane_q <= '0;
            end else if (capture && (cnt_q == CW'(gi))) begin
                lane_q <= fifo_data;
            end
        end

        assign acc_flat[gi*DATA_WIDTH +: DATA_WIDTH] = lane_q;
        assign keep_vec[gi] = (cnt_q > CW'(gi));
    end

    logic [OW+PACK_RATIO-1:0] out_payload;

    out_reg_slice #(
        .WIDTH(OW + PACK_RATIO)
    ) u_out (
        .clk    (clk),
        .reset  (reset),
        .s_valid(xfer_valid),
        .s_ready(xfer_ready),
        .s_data ({keep_vec, acc_flat}),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (out_payload)
    );

    assign m_data = out_payload[OW-1:0];
    assign m_keep = out_payload[OW+PACK_RATIO-1:OW];

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a behavioural sync FIFO upstream.
module tb_fifo_rd_packer;
    import fifo_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifo_rd_rdy;
    logic        fifo_rd_en;
    logic [7:0]  fifo_data = 8'h00;
    logic        flush;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;

    always #5 clk = ~clk;

    fifo_rd_packer #(
        .DATA_WIDTH(8),
        .PACK_RATIO(4),
        .TIMEOUT   (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_rd_rdy(fifo_rd_rdy),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_keep     (m_keep)
    );

    // Upstream FIFO model: data appears the cycle after a read strobe.
    logic [7:0] fmem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_rd_rdy = (wr_ptr != rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data <= fmem[rd_ptr % 256];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Output and strobe monitor, sampled mid-cycle.
    logic [31:0] rx_d[$];
    logic [3:0]  rx_k[$];
    int rd_cnt = 0;
    int valid_cnt = 0;
    int underflow_cnt = 0;

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            rx_d.push_back(m_data);
            rx_k.push_back(m_keep);
        end
        if (fifo_rd_en) rd_cnt++;
        if (fifo_rd_en && !fifo_rd_rdy) underflow_cnt++;
        if (m_valid) valid_cnt++;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fmem[wr_ptr % 256] = b;
        wr_ptr++;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while (rx_d.size() < n && k < budget) begin
            cyc(1);
            k++;
        end
        chk("rx_count_reached", 64'(rx_d.size()), 64'(n));
    endtask

    task automatic clear_rx();
        rx_d.delete();
        rx_k.delete();
    endtask

    initial begin
        int rd0;
        int v0;

        // Reset state
        reset   = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b0;
        cyc(3);
        @(negedge clk);
        chk("rst_m_valid", 64'(m_valid), 64'h0);
        chk("rst_m_keep", 64'(m_keep), 64'h0);
        chk("rst_m_data", 64'(m_data), 64'h0);
        cyc(1);
        reset = 1'b0;
        cyc(2);

        // Two full words, streaming
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(8'(i));
        wait_rx(2, 60);
        if (rx_d.size() >= 2) begin
            chk("full0_data", 64'(rx_d[0]), 64'h04030201);
            chk("full0_keep", 64'(rx_k[0]), 64'hF);
            chk("full1_data", 64'(rx_d[1]), 64'h08070605);
            chk("full1_keep", 64'(rx_k[1]), 64'hF);
        end
        clear_rx();
        cyc(5);

        // Partial word leaves on idle timeout
        push(8'hA1); push(8'hA2); push(8'hA3);
        cyc(10);
        chk("timeout_not_early", 64'(rx_d.size()), 64'h0);
        wait_rx(1, 60);
        if (rx_d.size() >= 1) begin
            chk("timeout_data", 64'(rx_d[0]), 64'h00A3A2A1);
            chk("timeout_keep", 64'(rx_k[0]), 64'h7);
        end
        clear_rx();
        cyc(5);

        // Flush while the second read is still in flight
        push(8'hB1); push(8'hB2);
        cyc(1);
        cyc(1);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        @(negedge clk);
        chk("drain_state", 64'(dut.state_q), 64'(DRAIN));
        cyc(1);
        wait_rx(1, 20);
        if (rx_d.size() >= 1) begin
            chk("flush_data", 64'(rx_d[0]), 64'h0000B2B1);
            chk("flush_keep", 64'(rx_k[0]), 64'h3);
        end
        cyc(30);
        chk("flush_no_extra", 64'(rx_d.size()), 64'h1);
        clear_rx();

        // Backpressure: one word held, one staged, reads stop
        m_ready = 1'b0;
        rd0 = rd_cnt;
        for (int i = 0; i < 12; i++) push(8'(8'h21 + i));
        cyc(30);
        @(negedge clk);
        chk("bp_rd_count", 64'(rd_cnt - rd0), 64'd8);
        chk("bp_valid", 64'(m_valid), 64'h1);
        chk("bp_hold_data", 64'(m_data), 64'h24232221);
        chk("bp_hold_keep", 64'(m_keep), 64'hF);
        cyc(5);
        @(negedge clk);
        chk("bp_stable_data", 64'(m_data), 64'h24232221);
        chk("bp_rd_stopped", 64'(rd_cnt - rd0), 64'd8);
        cyc(1);
        m_ready = 1'b1;
        wait_rx(3, 60);
        if (rx_d.size() >= 3) begin
            chk("bp_word0", 64'(rx_d[0]), 64'h24232221);
            chk("bp_word1", 64'(rx_d[1]), 64'h28272625);
            chk("bp_word2", 64'(rx_d[2]), 64'h2C2B2A29);
            chk("bp_keep2", 64'(rx_k[2]), 64'hF);
        end
        clear_rx();
        cyc(5);

        // Reset mid-word discards captured lanes
        push(8'h55); push(8'h66);
        cyc(5);
        reset = 1'b1;
        push(8'h10);
        @(negedge clk);
        chk("rst_rd_en_low", 64'(fifo_rd_en), 64'h0);
        cyc(2);
        reset = 1'b0;
        cyc(3);
        chk("rst_no_output", 64'(rx_d.size()), 64'h0);
        push(8'h11); push(8'h12); push(8'h13);
        wait_rx(1, 40);
        if (rx_d.size() >= 1) begin
            chk("rst_word_data", 64'(rx_d[0]), 64'h13121110);
            chk("rst_word_keep", 64'(rx_k[0]), 64'hF);
        end
        cyc(30);
        chk("rst_single_word", 64'(rx_d.size()), 64'h1);
        clear_rx();

        // Flush with nothing buffered is ignored
        rd0 = rd_cnt;
        v0  = valid_cnt;
        flush = 1'b1;
        cyc(4);
        flush = 1'b0;
        cyc(20);
        chk("empty_flush_rx", 64'(rx_d.size()), 64'h0);
        chk("empty_flush_valid", 64'(valid_cnt - v0), 64'h0);
        chk("empty_flush_rd", 64'(rd_cnt - rd0), 64'h0);

        chk("no_underflow", 64'(underflow_cnt), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
